deconv_cfg_ctrl: RTL and testbench

- Configuration sequencer for the per-PMT deconvolution pipelines in sde_trigger.
- Holds a shadow set and an active set of FD (decay) and FN (normaliser) constants per channel.
- Commits shadow to active only at a safe point: no trigger window open, and on an ENABLE40 boundary.
- After each commit, masks deconvoluted output until the pipelines have flushed.

---
 rtl/deconv_cfg_ctrl_pkg.sv | 14 +
 rtl/deconv_cfg_ctrl_if.sv | 20 ++
 rtl/deconv_cfg_bank.sv | 43 ++++
 rtl/deconv_cfg_ctrl.sv | 110 +++++++++++
 tb/tb_deconv_cfg_ctrl.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/deconv_cfg_ctrl_pkg.sv
// deconv_cfg_ctrl_pkg: shared widths, defaults and FSM encoding for the deconvolution config sequencer
package deconv_cfg_ctrl_pkg;
  localparam int FD_BITS = 6;
  localparam int FN_BITS = 6;
  localparam int FN_FRAC_BITS = 4;
  localparam int CHAN_BITS = 2;
  localparam logic [FN_BITS-1:0] FN_UNITY = 6'd16;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SAFE = 2'd1,
    APPLY     = 2'd2,
    SETTLE    = 2'd3
  } state_t;
endpackage

// File: rtl/deconv_cfg_ctrl_if.sv
// deconv_cfg_ctrl_if: host configuration bus (shadow writes, apply request, status)
interface deconv_cfg_ctrl_if;
  import deconv_cfg_ctrl_pkg::*;
  logic                 CFG_WR;
  logic [CHAN_BITS-1:0] CFG_CHAN;
  logic [FD_BITS-1:0]   CFG_FD;
  logic [FN_BITS-1:0]   CFG_FN;
  logic                 CFG_APPLY;
  logic                 CFG_BUSY;
  logic                 CFG_DONE;
  logic                 CFG_ERR;
  modport master (
    output CFG_WR, CFG_CHAN, CFG_FD, CFG_FN, CFG_APPLY,
    input  CFG_BUSY, CFG_DONE, CFG_ERR
  );
  modport slave (
    input  CFG_WR, CFG_CHAN, CFG_FD, CFG_FN, CFG_APPLY,
    output CFG_BUSY, CFG_DONE, CFG_ERR
  );
endinterface

// File: rtl/deconv_cfg_bank.sv
// deconv_cfg_bank: per-channel shadow/active FD-FN register pairs with write port and apply strobe
module deconv_cfg_bank
  import deconv_cfg_ctrl_pkg::*;
#(
  parameter int                 NCHAN    = 3,
  parameter logic [FD_BITS-1:0] FD_RESET = '0,
  parameter logic [FN_BITS-1:0] FN_RESET = FN_UNITY
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       wr,
  input  logic [CHAN_BITS-1:0]       chan,
  input  logic [FD_BITS-1:0]         fd,
  input  logic [FN_BITS-1:0]         fn,
  input  logic                       apply,
  output logic [NCHAN*FD_BITS-1:0]   fd_act,
  output logic [NCHAN*FN_BITS-1:0]   fn_act
);
  for (genvar k = 0; k < NCHAN; k++) begin : g_ch
    logic [FD_BITS-1:0] fd_sh, fd_a;
    logic [FN_BITS-1:0] fn_sh, fn_a;
    // shadow takes host writes; active copies the old shadow on apply, so a same-cycle write waits for the next apply
    always_ff @(posedge CLK) begin
      if (RST) begin
        fd_sh <= FD_RESET;
        fn_sh <= FN_RESET;
        fd_a  <= FD_RESET;
        fn_a  <= FN_RESET;
      end else begin
        if (wr && int'(chan) == k) begin
          fd_sh <= fd;
          fn_sh <= fn;
        end
        if (apply) begin
          fd_a <= fd_sh;
          fn_a <= fn_sh;
        end
      end
    end
    assign fd_act[k*FD_BITS +: FD_BITS] = fd_a;
    assign fn_act[k*FN_BITS +: FN_BITS] = fn_a;
  end
endmodule

// File: rtl/deconv_cfg_ctrl.sv
// deconv_cfg_ctrl: commits shadow FD/FN to active at a trigger-free ENABLE40 boundary, then masks output while pipelines flush
module deconv_cfg_ctrl
  import deconv_cfg_ctrl_pkg::*;
#(
  parameter int                 NCHAN         = 3,
  parameter logic [FD_BITS-1:0] FD_RESET      = '0,
  parameter logic [FN_BITS-1:0] FN_RESET      = FN_UNITY,
  parameter int                 SETTLE_CYCLES = 9,
  parameter int                 MAX_WAIT      = 4096
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENABLE40,
  input  logic                     TRIG_ACTIVE,
  deconv_cfg_ctrl_if.slave         bus,
  output logic [NCHAN*FD_BITS-1:0] FD_OUT,
  output logic [NCHAN*FN_BITS-1:0] FN_OUT,
  output logic                     DECONV_VALID
);
  localparam int WW = $clog2(MAX_WAIT);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(MAX_WAIT - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);
  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          valid_q, valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          apply_go, chan_ok, err_set, err_clr;
  assign chan_ok = int'(bus.CFG_CHAN) < NCHAN;
  deconv_cfg_bank #(
    .NCHAN(NCHAN), .FD_RESET(FD_RESET), .FN_RESET(FN_RESET)
  ) u_bank (
    .CLK(CLK), .RST(RST), .wr(bus.CFG_WR), .chan(bus.CFG_CHAN), .fd(bus.CFG_FD), .fn(bus.CFG_FN),
    .apply(apply_go), .fd_act(FD_OUT), .fn_act(FN_OUT)
  );
  // next state: accept apply in IDLE, wait for a safe 40 MHz edge, commit for one cycle, then settle
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    settle_d = settle_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    apply_go = 1'b0;
    err_set  = (bus.CFG_WR && !chan_ok) || (bus.CFG_APPLY && state_q != IDLE);
    err_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
        if (bus.CFG_APPLY) begin
          state_d = WAIT_SAFE;
          busy_d  = 1'b1;
          wait_d  = '0;
          err_clr = 1'b1;
        end
      end
      WAIT_SAFE: begin
        wait_d = wait_q == WAIT_LAST ? wait_q : wait_q + 1'b1;
        if (ENABLE40 && !TRIG_ACTIVE) state_d = APPLY;
        else if (wait_q == WAIT_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          err_set = 1'b1;
        end
      end
      APPLY: begin
        apply_go = 1'b1;
        valid_d  = 1'b0;
        settle_d = SETTLE_LOAD;
        state_d  = SETTLE;
      end
      SETTLE: begin
        valid_d  = 1'b0;
        settle_d = settle_q - 1'b1;
        if (settle_q == SW'(1)) begin
          state_d = IDLE;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = busy_q;
        end
      end
    endcase
    err_d = err_set || (err_q && !err_clr);
  end
  // state and registered outputs; reset enters SETTLE so output stays masked while pipelines fill
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= SETTLE;
      wait_q   <= '0;
      settle_q <= SETTLE_LOAD;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      settle_q <= settle_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  assign DECONV_VALID = valid_q;
  assign bus.CFG_BUSY = busy_q;
  assign bus.CFG_DONE = done_q;
  assign bus.CFG_ERR  = err_q;
endmodule

// File: tb/tb_deconv_cfg_ctrl.sv
// tb_deconv_cfg_ctrl: directed checks of reset release, commit timing, trigger hold-off, timeout and error paths
module tb_deconv_cfg_ctrl;
  import deconv_cfg_ctrl_pkg::*;
  logic CLK = 1'b0, RST = 1'b1, ENABLE40 = 1'b1, TRIG_ACTIVE = 1'b0;
  logic [17:0] fd_o, fn_o, fd16, fn16;
  logic valid, valid16;
  int cyc = 0, n_chk = 0, n_pass = 0;
  localparam logic [17:0] FD_DEF = '0;
  localparam logic [17:0] FN_DEF = {6'd16, 6'd16, 6'd16};
  localparam logic [17:0] FD_A = {6'd0, 6'd42, 6'd0};
  localparam logic [17:0] FN_A = {6'd16, 6'd20, 6'd16};
  localparam logic [17:0] FD_B = {6'd5, 6'd42, 6'd0};
  localparam logic [17:0] FN_B = {6'd33, 6'd20, 6'd16};
  localparam logic [17:0] FD_C = {6'd5, 6'd42, 6'd10};
  localparam logic [17:0] FN_C = {6'd33, 6'd20, 6'd17};
  deconv_cfg_ctrl_if bus();
  deconv_cfg_ctrl_if bus16();
  assign bus16.CFG_WR    = bus.CFG_WR;
  assign bus16.CFG_CHAN  = bus.CFG_CHAN;
  assign bus16.CFG_FD    = bus.CFG_FD;
  assign bus16.CFG_FN    = bus.CFG_FN;
  assign bus16.CFG_APPLY = bus.CFG_APPLY;
  deconv_cfg_ctrl u_dut (
    .CLK(CLK), .RST(RST), .ENABLE40(ENABLE40), .TRIG_ACTIVE(TRIG_ACTIVE), .bus(bus),
    .FD_OUT(fd_o), .FN_OUT(fn_o), .DECONV_VALID(valid)
  );
  deconv_cfg_ctrl #(.MAX_WAIT(16)) u_dut16 (
    .CLK(CLK), .RST(RST), .ENABLE40(ENABLE40), .TRIG_ACTIVE(TRIG_ACTIVE), .bus(bus16),
    .FD_OUT(fd16), .FN_OUT(fn16), .DECONV_VALID(valid16)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    ENABLE40 = (cyc % 3 == 0);
  endtask
  task automatic write(input int ch, input int fd, input int fn);
    bus.CFG_WR = 1'b1;
    bus.CFG_CHAN = 2'(ch);
    bus.CFG_FD = 6'(fd);
    bus.CFG_FN = 6'(fn);
    tick();
    bus.CFG_WR = 1'b0;
  endtask
  task automatic start();
    while (cyc % 3 != 0) tick();
    bus.CFG_APPLY = 1'b1;
    tick();
    bus.CFG_APPLY = 1'b0;
  endtask
  task automatic watch(input int from, input int upto, input int c,
                       input logic [17:0] ofd, input logic [17:0] ofn,
                       input logic [17:0] nfd, input logic [17:0] nfn);
    for (int i = from; i <= upto; i++) begin
      tick();
      check($sformatf("fd_out@%0d", i), 32'(fd_o), 32'(i >= c ? nfd : ofd));
      check($sformatf("fn_out@%0d", i), 32'(fn_o), 32'(i >= c ? nfn : ofn));
      check($sformatf("valid@%0d", i), 32'(valid), 32'(i < c || i >= c + 9));
      check($sformatf("done@%0d", i), 32'(bus.CFG_DONE), 32'(i == c + 9));
      check($sformatf("busy@%0d", i), 32'(bus.CFG_BUSY), 32'(i < c + 9));
    end
  endtask
  task automatic reset_seq();
    RST = 1'b1;
    tick();
    tick();
    check("rst_fd", 32'(fd_o), 32'(FD_DEF));
    check("rst_fn", 32'(fn_o), 32'(FN_DEF));
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(bus.CFG_BUSY), 32'd0);
    check("rst_done", 32'(bus.CFG_DONE), 32'd0);
    check("rst_err", 32'(bus.CFG_ERR), 32'd0);
    RST = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("rel_valid@%0d", i), 32'(valid), 32'(i == 9));
      check($sformatf("rel_done@%0d", i), 32'(bus.CFG_DONE), 32'd0);
      check($sformatf("rel_done16@%0d", i), 32'(bus16.CFG_DONE), 32'd0);
    end
  endtask
  initial begin
    bus.CFG_WR = 1'b0;
    bus.CFG_CHAN = '0;
    bus.CFG_FD = '0;
    bus.CFG_FN = '0;
    bus.CFG_APPLY = 1'b0;
    reset_seq();
    write(0, 7, 9);
    TRIG_ACTIVE = 1'b1;
    start();
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("to_err@%0d", i), 32'(bus16.CFG_ERR), 32'(i == 16));
      check($sformatf("to_busy@%0d", i), 32'(bus16.CFG_BUSY), 32'(i < 16));
      check($sformatf("to_done@%0d", i), 32'(bus16.CFG_DONE), 32'd0);
      check($sformatf("to_valid@%0d", i), 32'(valid16), 32'd1);
    end
    check("to_fd", 32'(fd16), 32'(FD_DEF));
    check("to_fn", 32'(fn16), 32'(FN_DEF));
    TRIG_ACTIVE = 1'b0;
    reset_seq();
    write(1, 42, 20);
    start();
    watch(1, 13, 4, FD_DEF, FN_DEF, FD_A, FN_A);
    write(2, 5, 33);
    TRIG_ACTIVE = 1'b1;
    start();
    watch(1, 100, 103, FD_A, FN_A, FD_B, FN_B);
    TRIG_ACTIVE = 1'b0;
    watch(101, 112, 103, FD_A, FN_A, FD_B, FN_B);
    check("hold_err", 32'(bus.CFG_ERR), 32'd0);
    write(3, 63, 63);
    check("bad_chan_err", 32'(bus.CFG_ERR), 32'd1);
    start();
    check("apply_clr_err", 32'(bus.CFG_ERR), 32'd0);
    watch(1, 5, 4, FD_B, FN_B, FD_B, FN_B);
    bus.CFG_APPLY = 1'b1;
    watch(6, 6, 4, FD_B, FN_B, FD_B, FN_B);
    bus.CFG_APPLY = 1'b0;
    check("busy_apply_err", 32'(bus.CFG_ERR), 32'd1);
    watch(7, 13, 4, FD_B, FN_B, FD_B, FN_B);
    start();
    watch(1, 3, 4, FD_B, FN_B, FD_B, FN_B);
    bus.CFG_WR = 1'b1;
    bus.CFG_CHAN = 2'd0;
    bus.CFG_FD = 6'd10;
    bus.CFG_FN = 6'd17;
    watch(4, 4, 4, FD_B, FN_B, FD_B, FN_B);
    bus.CFG_WR = 1'b0;
    watch(5, 13, 4, FD_B, FN_B, FD_B, FN_B);
    start();
    watch(1, 8, 4, FD_B, FN_B, FD_C, FN_C);
    reset_seq();
    start();
    watch(1, 13, 4, FD_DEF, FN_DEF, FD_DEF, FN_DEF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
